// File: rtl/seq_detect_ctrl.sv
// +--------------------------------------------------------------------------+
// | seq_detect_ctrl: programmable serial-pattern detector with arm/stop FSM, |
// | saturating match counter and threshold-driven done. Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_thresh,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  input  logic              x,
  input  logic              x_valid,
  output logic              match,
  output logic              done,
  output logic [CNTW-1:0]   count,
  output logic [1:0]        state
);

  localparam int BSW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic                cfg_loaded_q, cfg_loaded_d;
  logic [MAXLEN-1:0]   pattern_q, pattern_d;
  logic [3:0]          len_q, len_d;
  logic                overlap_q, overlap_d;
  logic [CNTW-1:0]     thresh_q, thresh_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [MAXLEN-2:0]   history_q, history_d;
  logic [BSW-1:0]      bits_seen_q, bits_seen_d;
  logic                done_q, done_d;
  logic                cfg_ready_q, cfg_ready_d;

  logic [MAXLEN-1:0]   window;
  logic [MAXLEN-1:0]   len_mask;
  logic [CNTW:0]       count_inc;
  logic                hit;
  logic                cfg_legal;
  logic                thresh_hit;

  // Only the newest len bits of the window take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign window     = {history_q, x};
  assign hit        = (int'(bits_seen_q) >= int'(len_q) - 1) &&
                      ((window & len_mask) == (pattern_q & len_mask));
  assign cfg_legal  = (cfg_len != 4'd0) && (int'(cfg_len) <= MAXLEN);
  assign count_inc  = {1'b0, count_q} + {{CNTW{1'b0}}, 1'b1};
  assign thresh_hit = (thresh_q != '0) && (count_inc >= {1'b0, thresh_q});
  assign match      = (state_q == ST_ARMED) && x_valid && hit && !stop;

  always_comb begin
    state_d      = state_q;
    cfg_loaded_d = cfg_loaded_q;
    pattern_d    = pattern_q;
    len_d        = len_q;
    overlap_d    = overlap_q;
    thresh_d     = thresh_q;
    cfg_err_d    = cfg_err_q;
    count_d      = count_q;
    history_d    = history_q;
    bits_seen_d  = bits_seen_q;

    if (cfg_valid && cfg_ready_q) begin
      cfg_err_d = !cfg_legal;
      if (cfg_legal) begin
        cfg_loaded_d = 1'b1;
        pattern_d    = cfg_pattern;
        len_d        = cfg_len;
        overlap_d    = cfg_overlap;
        thresh_d     = cfg_thresh;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // Arming looks at the registered cfg_loaded, not a same-cycle write.
        if (!stop && start && cfg_loaded_q) begin
          state_d     = ST_ARMED;
          count_d     = '0;
          history_d   = '0;
          bits_seen_d = '0;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (x_valid) begin
          history_d = window[MAXLEN-2:0];
          if (int'(bits_seen_q) < MAXLEN) begin
            bits_seen_d = bits_seen_q + 1'b1;
          end
          if (match) begin
            if (!(&count_q)) begin
              count_d = count_inc[CNTW-1:0];
            end
            if (!overlap_q) begin
              bits_seen_d = '0;
            end
            if (thresh_hit) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d     = ST_ARMED;
          count_d     = '0;
          history_d   = '0;
          bits_seen_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d      = (state_d == ST_DONE);
    cfg_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_loaded_q <= 1'b0;
      pattern_q    <= '0;
      len_q        <= '0;
      overlap_q    <= 1'b0;
      thresh_q     <= '0;
      cfg_err_q    <= 1'b0;
      count_q      <= '0;
      history_q    <= '0;
      bits_seen_q  <= '0;
      done_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cfg_loaded_q <= cfg_loaded_d;
      pattern_q    <= pattern_d;
      len_q        <= len_d;
      overlap_q    <= overlap_d;
      thresh_q     <= thresh_d;
      cfg_err_q    <= cfg_err_d;
      count_q      <= count_d;
      history_q    <= history_d;
      bits_seen_q  <= bits_seen_d;
      done_q       <= done_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign done      = done_q;
  assign count     = count_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_seq_detect_ctrl: scoreboard bench for seq_detect_ctrl. Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_detect_ctrl;

  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [MAXLEN-1:0] cfg_pattern = '0;
  logic [3:0]        cfg_len = '0;
  logic              cfg_overlap = 1'b0;
  logic [CNTW-1:0]   cfg_thresh = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              x = 1'b0;
  logic              x_valid = 1'b0;

  logic              cfg_ready, cfg_err, match, done;
  logic [CNTW-1:0]   count;
  logic [1:0]        state;

  logic              cfg_ready2, cfg_err2, match2, done2;
  logic [1:0]        count2;
  logic [1:0]        state2;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .start(start), .stop(stop),
    .x(x), .x_valid(x_valid), .match(match), .done(done), .count(count),
    .state(state)
  );

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_thresh(cfg_thresh[1:0]), .cfg_err(cfg_err2), .start(start), .stop(stop),
    .x(x), .x_valid(x_valid), .match(match2), .done(done2), .count(count2),
    .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard drain: every valid bit has one expected match value queued.
  always @(negedge clk) begin
    if (x_valid) begin
      check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("match", 32'(match), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic [7:0] thr);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_thresh  = thr;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send(input logic b, input logic stp, input logic e);
    x       = b;
    x_valid = 1'b1;
    stop    = stp;
    exp_q.push_back(e);
    tick();
    x_valid = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b0, exps[i]);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      x = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);

    // Illegal configs and start without a loaded config
    do_start();
    check("start_noload", 32'(state), 32'd0);
    do_cfg(8'h0E, 4'd0, 1'b1, 8'd0);
    check("err_len0", 32'(cfg_err), 32'd1);
    do_start();
    check("start_badcfg", 32'(state), 32'd0);
    start = 1'b1;
    do_cfg(8'h0E, 4'd4, 1'b1, 8'd0);
    start = 1'b0;
    check("cfg_start_same", 32'(state), 32'd0);
    check("err_clear", 32'(cfg_err), 32'd0);
    do_start();
    check("armed", 32'(state), 32'd1);
    check("ready_armed", 32'(cfg_ready), 32'd0);

    // 1110 overlapping, no threshold
    send_seq(16'b1111101110, 16'b0000010001, 10);
    check("t1_count", 32'(count), 32'd2);
    check("t1_done", 32'(done), 32'd0);
    do_stop();
    check("t1_stop_state", 32'(state), 32'd0);
    check("t1_stop_count", 32'(count), 32'd2);

    // 1010 overlap and non-overlap
    do_cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    do_start();
    send_seq(16'b10101010, 16'b00010101, 8);
    check("t2_ovl_count", 32'(count), 32'd3);
    do_stop();
    do_cfg(8'h0A, 4'd4, 1'b0, 8'd0);
    do_start();
    send_seq(16'b10101010, 16'b00010001, 8);
    check("t2_novl_count", 32'(count), 32'd2);
    do_stop();

    // Oversized length is rejected and the 1010 non-overlap config survives
    do_cfg(8'hFF, 4'd9, 1'b1, 8'd0);
    check("err_len9", 32'(cfg_err), 32'd1);
    do_start();
    send_seq(16'b101010, 16'b000100, 6);
    check("t5_count", 32'(count), 32'd1);
    do_stop();

    // Threshold of 2 moves to DONE
    do_cfg(8'h0E, 4'd4, 1'b1, 8'd2);
    do_start();
    send_seq(16'b111110111, 16'b000001000, 9);
    check("t3_done_pre", 32'(done), 32'd0);
    check("t3_count_pre", 32'(count), 32'd1);
    send(1'b0, 1'b0, 1'b1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_state", 32'(state), 32'd2);
    check("t3_count", 32'(count), 32'd2);
    send_seq(16'b1110, 16'b0000, 4);
    check("t3_frozen", 32'(count), 32'd2);
    do_start();
    check("t3_rearm_state", 32'(state), 32'd1);
    check("t3_rearm_count", 32'(count), 32'd0);
    check("t3_rearm_done", 32'(done), 32'd0);
    do_stop();

    // Gaps in x_valid, then stop on the final pattern bit
    do_cfg(8'h0E, 4'd4, 1'b1, 8'd0);
    do_start();
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    gap(3);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    check("t4_count", 32'(count), 32'd1);
    send_seq(16'b111, 16'b000, 3);
    send(1'b0, 1'b1, 1'b0);
    check("t4_stop_state", 32'(state), 32'd0);
    check("t4_stop_count", 32'(count), 32'd1);

    // Single-bit pattern, saturation on the narrow counter, async reset
    do_cfg(8'h01, 4'd1, 1'b1, 8'd0);
    do_start();
    send_seq(16'b11111, 16'b11111, 5);
    check("t6_count", 32'(count), 32'd5);
    check("t6_sat_count", 32'(count2), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_sat_count", 32'(count2), 32'd0);
    check("t6_rst_ready", 32'(cfg_ready), 32'd1);
    tick();
    rst = 1'b0;
    do_start();
    check("t6_cfg_lost", 32'(state), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
